// File: rtl/matrix_uart_printer_pkg.sv
// Shared constants, state encoding and sizing helper for the matrix printer.
package matrix_print_pkg;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] ZERO  = 8'h30;

    typedef enum logic [2:0] {
        IDLE, CHECK, CONV, EMIT_FIELD, EMIT_SEP, EMIT_CR, EMIT_LF, DONE
    } state_t;

    // Decimal digit count of the largest unsigned w-bit value.
    function automatic int calc_digits(input int w);
        longint v;
        int     d;
        v = (longint'(1) << w) - 1;
        d = 1;
        v = v / 10;
        while (v != 0) begin
            d = d + 1;
            v = v / 10;
        end
        return d;
    endfunction

endpackage

// File: rtl/matrix_uart_printer_if.sv
// Byte stream towards the UART transmitter (valid/ready).
interface matrix_uart_printer_if;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/matrix_uart_printer_bcd.sv
// Iterative double-dabble: one shift per cycle, ELEM_W cycles per conversion.
module bin_to_bcd_seq
    import matrix_print_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ELEM_W-1:0]     i_bin,
    output logic                  o_done,
    output logic [DIGITS*4-1:0]   o_bcd
);
    localparam int CNTW = $clog2(ELEM_W + 1);

    logic [ELEM_W-1:0]   r_bin;
    logic [DIGITS*4-1:0] r_bcd;
    logic [CNTW-1:0]     r_cnt;
    logic                r_done;
    logic [DIGITS*4-1:0] w_adj;

    // Add 3 to every digit >= 5 before the next shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Load on start, then shift until the counter drains; done pulses with the last shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= CNTW'(ELEM_W);
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            {r_bcd, r_bin} <= {w_adj[DIGITS*4-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt - CNTW'(1);
            r_done         <= (r_cnt == CNTW'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/matrix_uart_printer.sv
// Streams a snapshot matrix as right-aligned decimal text rows over a byte handshake.
module matrix_uart_printer
    import matrix_print_pkg::*;
#(
    parameter int MAX_ROWS = 5,
    parameter int MAX_COLS = 5,
    parameter int ELEM_W   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [MAX_ROWS*MAX_COLS*ELEM_W-1:0]   data_in,
    input  logic [$clog2(MAX_ROWS+1)-1:0]         rows,
    input  logic [$clog2(MAX_COLS+1)-1:0]         cols,
    input  logic                                  signed_mode,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err,
    matrix_uart_printer_if.master                 uart
);
    localparam int NELEM  = MAX_ROWS * MAX_COLS;
    localparam int RW     = $clog2(MAX_ROWS + 1);
    localparam int CW     = $clog2(MAX_COLS + 1);
    localparam int KW     = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int DIGITS = calc_digits(ELEM_W);
    localparam int JW     = 3;

    state_t                          r_state, w_nstate;
    logic [NELEM-1:0][ELEM_W-1:0]    r_data;
    logic [RW-1:0]                   r_rows, r_row, w_nrow;
    logic [CW-1:0]                   r_cols, r_col, w_ncol;
    logic [KW-1:0]                   r_k, w_nk, w_conv_idx;
    logic [JW-1:0]                   r_j, w_nj, w_fw_last;
    logic                            r_sgn, r_neg;
    logic [7:0]                      r_dout, w_ndout;
    logic                            r_valid, w_nvalid;
    logic                            r_busy, r_done, r_err, w_ndone, w_nerr;
    logic                            w_conv_start, w_cv_done, w_accept, w_neg_el;
    logic [ELEM_W-1:0]               w_elem, w_mag;
    logic [DIGITS*4-1:0]             w_bcd;

    // Byte j of a field: spaces, optional '-' just left of the top significant digit, digits.
    function automatic logic [7:0] field_byte(input logic [JW-1:0] j, input logic sgn,
                                              input logic neg, input logic [DIGITS*4-1:0] bcd);
        int nd, fw, p;
        nd = 1;
        for (int i = 1; i < DIGITS; i++)
            if (bcd[i*4 +: 4] != 4'd0) nd = i + 1;
        fw = sgn ? DIGITS + 1 : DIGITS;
        p  = fw - 1 - int'(j);
        if (p < nd)               return ZERO + {4'd0, bcd[p*4 +: 4]};
        else if (neg && p == nd)  return MINUS;
        else                      return SPACE;
    endfunction

    assign w_accept  = r_valid & uart.dout_ready;
    assign w_fw_last = r_sgn ? JW'(DIGITS) : JW'(DIGITS - 1);
    assign w_elem    = r_data[w_conv_idx];
    assign w_neg_el  = r_sgn & w_elem[ELEM_W-1];
    assign w_mag     = w_neg_el ? (~w_elem + ELEM_W'(1)) : w_elem;

    bin_to_bcd_seq #(.ELEM_W(ELEM_W), .DIGITS(DIGITS)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_conv_start),
        .i_bin   (w_mag),
        .o_done  (w_cv_done),
        .o_bcd   (w_bcd)
    );

    // Next state, counters and next output byte; bytes only move on acceptance.
    always_comb begin
        w_nstate     = r_state;
        w_ndout      = r_dout;
        w_nvalid     = r_valid;
        w_nrow       = r_row;
        w_ncol       = r_col;
        w_nk         = r_k;
        w_nj         = r_j;
        w_conv_start = 1'b0;
        w_conv_idx   = r_k + KW'(1);
        w_ndone      = 1'b0;
        w_nerr       = 1'b0;
        case (r_state)
            IDLE: begin
                w_nvalid = 1'b0;
                if (start) w_nstate = CHECK;
            end
            CHECK: begin
                if (r_rows == '0 || r_cols == '0 ||
                    int'(r_rows) > MAX_ROWS || int'(r_cols) > MAX_COLS) begin
                    w_nerr   = 1'b1;
                    w_nstate = IDLE;
                end else begin
                    w_nk         = '0;
                    w_nrow       = '0;
                    w_ncol       = '0;
                    w_conv_idx   = '0;
                    w_conv_start = 1'b1;
                    w_nstate     = CONV;
                end
            end
            CONV: begin
                if (w_cv_done) begin
                    w_nj     = '0;
                    w_ndout  = field_byte('0, r_sgn, r_neg, w_bcd);
                    w_nvalid = 1'b1;
                    w_nstate = EMIT_FIELD;
                end
            end
            EMIT_FIELD: begin
                if (w_accept) begin
                    if (r_j == w_fw_last) begin
                        if (r_col != r_cols - CW'(1)) begin
                            w_ndout  = SPACE;
                            w_nstate = EMIT_SEP;
                        end else begin
                            w_ndout  = CR;
                            w_nstate = EMIT_CR;
                        end
                    end else begin
                        w_nj    = r_j + JW'(1);
                        w_ndout = field_byte(r_j + JW'(1), r_sgn, r_neg, w_bcd);
                    end
                end
            end
            EMIT_SEP: begin
                if (w_accept) begin
                    w_nvalid     = 1'b0;
                    w_conv_start = 1'b1;
                    w_nk         = r_k + KW'(1);
                    w_ncol       = r_col + CW'(1);
                    w_nstate     = CONV;
                end
            end
            EMIT_CR: begin
                if (w_accept) begin
                    w_ndout  = LF;
                    w_nstate = EMIT_LF;
                end
            end
            EMIT_LF: begin
                if (w_accept) begin
                    w_nvalid = 1'b0;
                    if (r_row == r_rows - RW'(1)) begin
                        w_ndone  = 1'b1;
                        w_nstate = DONE;
                    end else begin
                        w_conv_start = 1'b1;
                        w_nk         = r_k + KW'(1);
                        w_ncol       = '0;
                        w_nrow       = r_row + RW'(1);
                        w_nstate     = CONV;
                    end
                end
            end
            DONE:    w_nstate = IDLE;
            default: w_nstate = IDLE;
        endcase
    end

    // State, counters, registered outputs, and the input snapshot taken on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rows  <= '0;
            r_cols  <= '0;
            r_sgn   <= 1'b0;
            r_neg   <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_data <= data_in;
                r_rows <= rows;
                r_cols <= cols;
                r_sgn  <= signed_mode;
            end
            if (w_conv_start) r_neg <= w_neg_el;
            r_state <= w_nstate;
            r_row   <= w_nrow;
            r_col   <= w_ncol;
            r_k     <= w_nk;
            r_j     <= w_nj;
            r_dout  <= w_ndout;
            r_valid <= w_nvalid;
            r_busy  <= (w_nstate != IDLE);
            r_done  <= w_ndone;
            r_err   <= w_nerr;
        end
    end

    assign uart.dout       = r_dout;
    assign uart.dout_valid = r_valid;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;

endmodule
